// File: rtl/dcache_assoc_pkg.sv
// Shared types for the set-associative data cache.
// Holds bus typedefs, the tag-array entry and the store merge helper.
package dcache_assoc_pkg;

    localparam int TAG_MAX = 32;

    typedef logic [31:0] ADDR;
    typedef logic [31:0] DATA;
    typedef logic [63:0] MEM_BLOCK;

    typedef enum logic [1:0] {
        BYTE = 2'h0,
        HALF = 2'h1,
        WORD = 2'h2
    } MEM_SIZE;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
    } DCACHE_ASSOC_TAG;

    typedef enum logic {
        IDLE    = 1'b0,
        WB_WAIT = 1'b1
    } dc_state_e;

    function automatic MEM_BLOCK merge_store(
        input MEM_BLOCK   line,
        input logic [2:0] off,
        input MEM_SIZE    size,
        input DATA        data
    );
        MEM_BLOCK m;
        m = line;
        case (size)
            BYTE:    m[{off, 3'b000} +: 8]        = data[7:0];
            HALF:    m[{off[2:1], 4'b0000} +: 16] = data[15:0];
            WORD:    m[{off[2], 5'b00000} +: 32]  = data;
            default: m = line;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dcache_assoc_lru.sv
// Per-set LRU tracker built from an age matrix.
// Row i set in column j means way i was used more recently than way j.
module lru_tracker
    import dcache_assoc_pkg::*;
#(
    parameter  int WAYS = 2,
    parameter  int SETS = 16,
    localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int SB   = $clog2(SETS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_touch,
    input  logic [SB-1:0] i_touch_set,
    input  logic [WB-1:0] i_touch_way,
    input  logic [SB-1:0] i_set,
    output logic [WB-1:0] o_victim
);

    logic [WAYS-1:0][WAYS-1:0] r_age [SETS];
    logic                      w_row_zero;
    logic                      w_found;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++)
                r_age[s] <= '0;
        end else if (i_touch) begin
            for (int i = 0; i < WAYS; i++)
                for (int j = 0; j < WAYS; j++)
                    if (i != j) begin
                        if (WB'(i) == i_touch_way)
                            r_age[i_touch_set][i][j] <= 1'b1;
                        else if (WB'(j) == i_touch_way)
                            r_age[i_touch_set][i][j] <= 1'b0;
                    end
        end
    end

    // The least recent way is the lowest one newer than nobody
    always_comb begin
        o_victim   = '0;
        w_found    = 1'b0;
        w_row_zero = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            w_row_zero = 1'b1;
            for (int j = 0; j < WAYS; j++)
                if (i != j && r_age[i_set][i][j])
                    w_row_zero = 1'b0;
            if (w_row_zero && !w_found) begin
                w_found  = 1'b1;
                o_victim = WB'(i);
            end
        end
    end

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache.
// Registered responses, miss request and dirty-eviction handshakes.
module dcache_assoc
    import dcache_assoc_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SETS      = 16,
    parameter int ADDR_BITS = 16
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     req_valid,
    output logic     req_ready,
    input  ADDR      req_addr,
    input  logic     req_store,
    input  MEM_SIZE  req_size,
    input  DATA      req_data,
    output logic     resp_valid,
    output logic     resp_hit,
    output MEM_BLOCK resp_data,
    output ADDR      resp_addr,
    output logic     miss_valid,
    output ADDR      miss_addr,
    input  logic     miss_ready,
    input  logic     fill_valid,
    input  ADDR      fill_addr,
    input  MEM_BLOCK fill_block,
    output logic     wb_valid,
    output ADDR      wb_addr,
    output MEM_BLOCK wb_block,
    input  logic     wb_ready
);

    localparam int IB = $clog2(SETS);
    localparam int TB = ADDR_BITS - 3 - IB;
    localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;

    DCACHE_ASSOC_TAG r_tags [SETS][WAYS];
    MEM_BLOCK        r_data [SETS][WAYS];
    dc_state_e       r_state, w_state_nxt;

    logic r_resp_valid, r_resp_hit, r_miss_valid, r_wb_valid;
    MEM_BLOCK r_resp_data, r_wb_block, r_fill_block;
    ADDR r_resp_addr, r_miss_addr, r_wb_addr, r_fill_addr;
    logic [WB-1:0] r_fill_way;

    logic [IB-1:0] w_req_set, w_fill_set, w_inst_set;
    logic [TAG_MAX-1:0] w_req_tag, w_fill_tag, w_inst_tag;
    logic [WB-1:0] w_req_way, w_fill_hway, w_fill_inv;
    logic [WB-1:0] w_fill_way, w_lru_way, w_inst_way;
    logic w_req_hit, w_fill_hit, w_fill_has_inv;
    logic w_accept, w_req_ready, w_install, w_evict, w_wb_done;
    logic w_inst_en, w_touch, w_fill_dirty, w_unused;
    MEM_BLOCK w_resp_line, w_inst_block;
    DCACHE_ASSOC_TAG w_victim;

    assign w_req_set  = req_addr[IB+2:3];
    assign w_fill_set = fill_addr[IB+2:3];
    assign w_req_tag  = TAG_MAX'(req_addr[ADDR_BITS-1:IB+3]);
    assign w_fill_tag = TAG_MAX'(fill_addr[ADDR_BITS-1:IB+3]);

    always_comb begin
        w_req_hit      = 1'b0;
        w_req_way      = '0;
        w_fill_hit     = 1'b0;
        w_fill_hway    = '0;
        w_fill_has_inv = 1'b0;
        w_fill_inv     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_tags[w_req_set][w].valid &&
                r_tags[w_req_set][w].tag == w_req_tag) begin
                w_req_hit = 1'b1;
                w_req_way = WB'(w);
            end
            if (r_tags[w_fill_set][w].valid &&
                r_tags[w_fill_set][w].tag == w_fill_tag) begin
                w_fill_hit  = 1'b1;
                w_fill_hway = WB'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_tags[w_fill_set][w].valid) begin
                w_fill_has_inv = 1'b1;
                w_fill_inv     = WB'(w);
            end
    end

    // A refill of a resident block reuses its way and never evicts
    assign w_fill_way = w_fill_hit     ? w_fill_hway :
                        w_fill_has_inv ? w_fill_inv  : w_lru_way;
    assign w_victim     = r_tags[w_fill_set][w_fill_way];
    assign w_fill_dirty = !w_fill_hit && w_victim.valid && w_victim.dirty;

    always_comb begin
        w_state_nxt = r_state;
        w_install   = 1'b0;
        w_evict     = 1'b0;
        w_wb_done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (fill_valid) begin
                    if (w_fill_dirty) begin
                        w_evict     = 1'b1;
                        w_state_nxt = WB_WAIT;
                    end else begin
                        w_install = 1'b1;
                    end
                end
            end
            WB_WAIT: begin
                if (wb_ready) begin
                    w_wb_done   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_req_ready = (r_state == IDLE) && !fill_valid &&
                         !(r_miss_valid && !miss_ready && !w_req_hit);
    assign w_accept    = req_valid && w_req_ready;

    assign w_resp_line = req_store ?
        merge_store(r_data[w_req_set][w_req_way],
                    req_addr[2:0], req_size, req_data) :
        r_data[w_req_set][w_req_way];

    assign w_inst_en    = w_install || w_wb_done;
    assign w_inst_set   = w_wb_done ? r_fill_addr[IB+2:3] : w_fill_set;
    assign w_inst_tag   = w_wb_done ?
        TAG_MAX'(r_fill_addr[ADDR_BITS-1:IB+3]) : w_fill_tag;
    assign w_inst_way   = w_wb_done ? r_fill_way : w_fill_way;
    assign w_inst_block = w_wb_done ? r_fill_block : fill_block;
    assign w_touch      = w_inst_en || (w_accept && w_req_hit);

    lru_tracker #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_touch     (w_touch),
        .i_touch_set (w_inst_en ? w_inst_set : w_req_set),
        .i_touch_way (w_inst_en ? w_inst_way : w_req_way),
        .i_set       (w_fill_set),
        .o_victim    (w_lru_way)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_tags[s][w] <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_data  <= '0;
            r_resp_addr  <= '0;
            r_miss_valid <= 1'b0;
            r_miss_addr  <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_block   <= '0;
            r_fill_addr  <= '0;
            r_fill_block <= '0;
            r_fill_way   <= '0;
        end else begin
            r_resp_valid <= w_accept;
            if (w_accept) begin
                r_resp_hit  <= w_req_hit;
                r_resp_data <= w_req_hit ? w_resp_line : '0;
                r_resp_addr <= {req_addr[31:3], 3'b000};
            end
            if (w_accept && !w_req_hit) begin
                r_miss_valid <= 1'b1;
                r_miss_addr  <= {req_addr[31:3], 3'b000};
            end else if (miss_ready) begin
                r_miss_valid <= 1'b0;
            end
            if (w_accept && req_store && w_req_hit)
                r_tags[w_req_set][w_req_way].dirty <= 1'b1;
            if (w_inst_en)
                r_tags[w_inst_set][w_inst_way] <= '{
                    valid: 1'b1, dirty: 1'b0, tag: w_inst_tag};
            if (w_evict) begin
                r_wb_valid   <= 1'b1;
                r_wb_addr    <= 32'({w_victim.tag[TB-1:0],
                                     w_fill_set, 3'b000});
                r_wb_block   <= r_data[w_fill_set][w_fill_way];
                r_fill_addr  <= fill_addr;
                r_fill_block <= fill_block;
                r_fill_way   <= w_fill_way;
            end else if (w_wb_done) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept && req_store && w_req_hit)
            r_data[w_req_set][w_req_way] <= w_resp_line;
        if (w_inst_en)
            r_data[w_inst_set][w_inst_way] <= w_inst_block;
    end

    assign w_unused   = ^{req_addr, fill_addr, r_fill_addr};
    assign req_ready  = w_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_data  = r_resp_data;
    assign resp_addr  = r_resp_addr;
    assign miss_valid = r_miss_valid;
    assign miss_addr  = r_miss_addr;
    assign wb_valid   = r_wb_valid;
    assign wb_addr    = r_wb_addr;
    assign wb_block   = r_wb_block;

endmodule
